// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = datapath side (drives hazard inputs), slave = controller side.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_LEN = 4,
  parameter int CNT_LEN      = 16
);
  logic                    fwd_en;
  logic [REG_ADDR_LEN-1:0] id_src1;
  logic [REG_ADDR_LEN-1:0] id_src2;
  logic                    id_use_src1;
  logic                    id_use_src2;
  logic                    exe_wb_en;
  logic [REG_ADDR_LEN-1:0] exe_dest;
  logic                    exe_mem_read;
  logic                    mem_wb_en;
  logic [REG_ADDR_LEN-1:0] mem_dest;
  logic                    branch_taken;
  logic                    mem_req;
  logic                    mem_ready;
  logic                    clr_stats;
  logic                    pc_freeze;
  logic                    if_freeze;
  logic                    if_flush;
  logic                    id_flush;
  logic                    pipe_freeze;
  logic                    mem_timeout;
  logic [CNT_LEN-1:0]      stall_cnt;
  logic [CNT_LEN-1:0]      flush_cnt;
  logic [CNT_LEN-1:0]      wait_cnt;
  logic [1:0]              state;

  // Handshake: mem_req/mem_ready form a valid/ready pair; an access is
  // outstanding (and the pipe frozen) in every cycle with mem_req=1 and
  // mem_ready=0, and completes in the cycle where both are 1.
  modport master (
    output fwd_en, id_src1, id_src2, id_use_src1, id_use_src2,
           exe_wb_en, exe_dest, exe_mem_read, mem_wb_en, mem_dest,
           branch_taken, mem_req, mem_ready, clr_stats,
    input  pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze,
           mem_timeout, stall_cnt, flush_cnt, wait_cnt, state
  );

  modport slave (
    input  fwd_en, id_src1, id_src2, id_use_src1, id_use_src2,
           exe_wb_en, exe_dest, exe_mem_read, mem_wb_en, mem_dest,
           branch_taken, mem_req, mem_ready, clr_stats,
    output pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze,
           mem_timeout, stall_cnt, flush_cnt, wait_cnt, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline freeze/flush controller: memory wait > taken branch > RAW hazard,
// with a memory-wait timeout FSM and saturating statistic counters.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_LEN = 4,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_LEN      = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] TIMEOUT  = 2'd2;

  logic [1:0]         state, nxt_state;
  logic [TW-1:0]      tcnt, nxt_tcnt;
  logic [CNT_LEN-1:0] stall_q, flush_q, wait_q;

  logic mem_stall, hazard, src1_hit, src2_hit;
  logic pc_f, if_fr, if_fl, id_fl, pipe_f;
  logic stall_inc, wait_inc;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;

  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    src1_hit = 1'b0;
    src2_hit = 1'b0;
    if (bus.fwd_en) begin
      src1_hit = bus.exe_mem_read & bus.exe_wb_en & (bus.id_src1 == bus.exe_dest);
      src2_hit = bus.exe_mem_read & bus.exe_wb_en & (bus.id_src2 == bus.exe_dest);
    end else begin
      src1_hit = (bus.exe_wb_en & (bus.id_src1 == bus.exe_dest)) |
                 (bus.mem_wb_en & (bus.id_src1 == bus.mem_dest));
      src2_hit = (bus.exe_wb_en & (bus.id_src2 == bus.exe_dest)) |
                 (bus.mem_wb_en & (bus.id_src2 == bus.mem_dest));
    end
    hazard = (bus.id_use_src1 & src1_hit) | (bus.id_use_src2 & src2_hit);
  end

  always_comb begin
    pc_f      = 1'b0;
    if_fr     = 1'b0;
    if_fl     = 1'b0;
    id_fl     = 1'b0;
    pipe_f    = 1'b0;
    stall_inc = 1'b0;
    wait_inc  = 1'b0;
    nxt_state = state;
    nxt_tcnt  = tcnt;
    if (state == TIMEOUT) begin
      pc_f     = 1'b1;
      if_fr    = 1'b1;
      pipe_f   = 1'b1;
      wait_inc = mem_stall;
    end else if (mem_stall) begin
      pc_f     = 1'b1;
      if_fr    = 1'b1;
      pipe_f   = 1'b1;
      wait_inc = 1'b1;
      if (state == RUN) begin
        nxt_state = MEM_WAIT;
        nxt_tcnt  = TW'(1);
      end else begin
        nxt_tcnt = tcnt + TW'(1);
        if (nxt_tcnt == TW'(MEM_TIMEOUT)) nxt_state = TIMEOUT;
      end
    end else begin
      // Access done (or none pending): branch and hazard act this cycle.
      nxt_state = RUN;
      nxt_tcnt  = '0;
      if (bus.branch_taken) begin
        if_fl = 1'b1;
        id_fl = 1'b1;
      end else if (hazard) begin
        pc_f      = 1'b1;
        if_fr     = 1'b1;
        id_fl     = 1'b1;
        stall_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      tcnt    <= '0;
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      state <= nxt_state;
      tcnt  <= nxt_tcnt;
      if (bus.clr_stats) begin
        stall_q <= '0;
        flush_q <= '0;
        wait_q  <= '0;
      end else begin
        if (stall_inc && !(&stall_q)) stall_q <= stall_q + 1'b1;
        if (if_fl && !(&flush_q))     flush_q <= flush_q + 1'b1;
        if (wait_inc && !(&wait_q))   wait_q  <= wait_q + 1'b1;
      end
    end
  end

  assign bus.pc_freeze   = rst & pc_f;
  assign bus.if_freeze   = rst & if_fr;
  assign bus.if_flush    = rst & if_fl;
  assign bus.id_flush    = rst & id_fl;
  assign bus.pipe_freeze = rst & pipe_f;
  assign bus.mem_timeout = rst & (state == TIMEOUT);
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;
  assign bus.wait_cnt    = wait_q;
  assign bus.state       = state;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MEM_TIMEOUT=8, CNT_LEN=4).
module tb_pipe_hazard_ctrl;
  localparam int RA = 4;
  localparam int CL = 4;
  localparam int MT = 8;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_TO   = 2'd2;

  // control vector order: pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze
  localparam logic [4:0] C_NONE   = 5'b00000;
  localparam logic [4:0] C_BUBBLE = 5'b11010;
  localparam logic [4:0] C_FLUSH  = 5'b00110;
  localparam logic [4:0] C_FREEZE = 5'b11001;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [4:0] ctl;

  pipe_hazard_ctrl_if #(.REG_ADDR_LEN(RA), .CNT_LEN(CL)) bus ();

  pipe_hazard_ctrl #(.REG_ADDR_LEN(RA), .MEM_TIMEOUT(MT), .CNT_LEN(CL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign ctl = {bus.pc_freeze, bus.if_freeze, bus.if_flush, bus.id_flush, bus.pipe_freeze};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fwd_en       = 1'b0;
    bus.id_src1      = '0;
    bus.id_src2      = '0;
    bus.id_use_src1  = 1'b0;
    bus.id_use_src2  = 1'b0;
    bus.exe_wb_en    = 1'b0;
    bus.exe_dest     = 4'd15;
    bus.exe_mem_read = 1'b0;
    bus.mem_wb_en    = 1'b0;
    bus.mem_dest     = 4'd14;
    bus.branch_taken = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.clr_stats    = 1'b0;
    #1;
  endtask

  task automatic set_exe_hazard();
    bus.id_src1     = 4'd3;
    bus.id_use_src1 = 1'b1;
    bus.exe_wb_en   = 1'b1;
    bus.exe_dest    = 4'd3;
    #1;
  endtask

  task automatic clear_stats();
    bus.clr_stats = 1'b1;
    tick();
    bus.clr_stats = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    set_exe_hazard();
    bus.mem_req = 1'b1;
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_NONE); end
    tick();
    checks++;
    if (bus.state !== S_RUN || bus.mem_timeout !== 1'b0) begin
      failures++; $display("FAIL reset_state got=%0d/%b exp=%0d/0", bus.state, bus.mem_timeout, S_RUN);
    end
    checks++;
    if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0 || bus.wait_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_cnts got=%0d/%0d/%0d exp=0/0/0", bus.stall_cnt, bus.flush_cnt, bus.wait_cnt);
    end
    idle_inputs();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_hazard_nofwd();
    set_exe_hazard();
    checks++;
    if (ctl !== C_BUBBLE) begin failures++; $display("FAIL hz_exe_ctl got=%b exp=%b", ctl, C_BUBBLE); end
    tick();
    checks++;
    if (bus.stall_cnt !== 4'd1) begin failures++; $display("FAIL hz_exe_cnt got=%0d exp=1", bus.stall_cnt); end
    idle_inputs();
    bus.id_src2     = 4'd5;
    bus.id_use_src2 = 1'b1;
    bus.mem_wb_en   = 1'b1;
    bus.mem_dest    = 4'd5;
    #1;
    checks++;
    if (ctl !== C_BUBBLE) begin failures++; $display("FAIL hz_mem_src2_ctl got=%b exp=%b", ctl, C_BUBBLE); end
    tick();
    checks++;
    if (bus.stall_cnt !== 4'd2) begin failures++; $display("FAIL hz_mem_src2_cnt got=%0d exp=2", bus.stall_cnt); end
    bus.id_use_src2 = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL hz_unused_src_ctl got=%b exp=%b", ctl, C_NONE); end
    idle_inputs();
  endtask

  task automatic test_fwd();
    bus.fwd_en = 1'b1;
    set_exe_hazard();
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL fwd_alu_ctl got=%b exp=%b", ctl, C_NONE); end
    tick();
    checks++;
    if (bus.stall_cnt !== 4'd2) begin failures++; $display("FAIL fwd_alu_cnt got=%0d exp=2", bus.stall_cnt); end
    bus.exe_mem_read = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BUBBLE) begin failures++; $display("FAIL fwd_load_use_ctl got=%b exp=%b", ctl, C_BUBBLE); end
    tick();
    checks++;
    if (bus.stall_cnt !== 4'd3) begin failures++; $display("FAIL fwd_load_use_cnt got=%0d exp=3", bus.stall_cnt); end
    bus.exe_dest  = 4'd7;
    bus.mem_wb_en = 1'b1;
    bus.mem_dest  = 4'd3;
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL fwd_mem_only_ctl got=%b exp=%b", ctl, C_NONE); end
    idle_inputs();
  endtask

  task automatic test_branch();
    clear_stats();
    checks++;
    if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0 || bus.wait_cnt !== 4'd0) begin
      failures++; $display("FAIL clr_cnts got=%0d/%0d/%0d exp=0/0/0", bus.stall_cnt, bus.flush_cnt, bus.wait_cnt);
    end
    set_exe_hazard();
    bus.branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin failures++; $display("FAIL br_hz_ctl got=%b exp=%b", ctl, C_FLUSH); end
    tick();
    checks++;
    if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd0) begin
      failures++; $display("FAIL br_hz_cnts got=%0d/%0d exp=1/0", bus.flush_cnt, bus.stall_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    bus.mem_req      = 1'b1;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ctl !== C_FREEZE) begin failures++; $display("FAIL mw_freeze_%0d got=%b exp=%b", i, ctl, C_FREEZE); end
      tick();
    end
    checks++;
    if (bus.state !== S_WAIT) begin failures++; $display("FAIL mw_state got=%0d exp=%0d", bus.state, S_WAIT); end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FLUSH) begin failures++; $display("FAIL mw_done_ctl got=%b exp=%b", ctl, C_FLUSH); end
    tick();
    checks++;
    if (bus.state !== S_RUN || bus.wait_cnt !== 4'd5 || bus.flush_cnt !== 4'd2) begin
      failures++; $display("FAIL mw_done got=%0d/%0d/%0d exp=%0d/5/2", bus.state, bus.wait_cnt, bus.flush_cnt, S_RUN);
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    clear_stats();
    set_exe_hazard();
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (bus.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", bus.stall_cnt); end
    tick();
    checks++;
    if (bus.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold2 got=%0d exp=15", bus.stall_cnt); end
    bus.clr_stats = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BUBBLE) begin failures++; $display("FAIL sat_clr_ctl got=%b exp=%b", ctl, C_BUBBLE); end
    tick();
    checks++;
    if (bus.stall_cnt !== 4'd0) begin failures++; $display("FAIL sat_clr_prio got=%0d exp=0", bus.stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    clear_stats();
    bus.mem_req   = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    for (int i = 0; i < MT - 1; i++) tick();
    checks++;
    if (bus.mem_timeout !== 1'b0 || bus.state !== S_WAIT) begin
      failures++; $display("FAIL to_early got=%b/%0d exp=0/%0d", bus.mem_timeout, bus.state, S_WAIT);
    end
    tick();
    checks++;
    if (bus.mem_timeout !== 1'b1 || bus.state !== S_TO) begin
      failures++; $display("FAIL to_set got=%b/%0d exp=1/%0d", bus.mem_timeout, bus.state, S_TO);
    end
    checks++;
    if (bus.wait_cnt !== 4'd8) begin failures++; $display("FAIL to_wait_cnt got=%0d exp=8", bus.wait_cnt); end
    bus.mem_ready    = 1'b1;
    bus.branch_taken = 1'b1;
    #1;
    checks++;
    if (ctl !== C_FREEZE) begin failures++; $display("FAIL to_ready_ctl got=%b exp=%b", ctl, C_FREEZE); end
    idle_inputs();
    clear_stats();
    checks++;
    if (bus.mem_timeout !== 1'b1 || ctl !== C_FREEZE) begin
      failures++; $display("FAIL to_clr_sticky got=%b/%b exp=1/%b", bus.mem_timeout, ctl, C_FREEZE);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE || bus.mem_timeout !== 1'b0 || bus.state !== S_RUN) begin
      failures++; $display("FAIL to_rst got=%b/%b/%0d exp=%b/0/%0d", ctl, bus.mem_timeout, bus.state, C_NONE, S_RUN);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bus.mem_req = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.state !== S_WAIT || bus.wait_cnt !== 4'd3) begin
      failures++; $display("FAIL rmw_pre got=%0d/%0d exp=%0d/3", bus.state, bus.wait_cnt, S_WAIT);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== C_NONE || bus.state !== S_RUN || bus.wait_cnt !== 4'd0) begin
      failures++; $display("FAIL rmw_rst got=%b/%0d/%0d exp=%b/%0d/0", ctl, bus.state, bus.wait_cnt, C_NONE, S_RUN);
    end
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (ctl !== C_NONE || bus.state !== S_RUN) begin
      failures++; $display("FAIL rmw_after got=%b/%0d exp=%b/%0d", ctl, bus.state, C_NONE, S_RUN);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_hazard_nofwd();
    test_fwd();
    test_branch();
    test_mem_wait();
    test_saturate();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage ARM core. Generates freeze/flush for the PC, the IF/ID register and the ID/EXE register, plus a global freeze for the downstream pipeline registers.
- Resolves three event classes at fixed priority:
  - memory wait from the SRAM path, highest;
  - taken branch from EXE;
  - RAW data hazard between the ID sources and the EXE/MEM destinations, lowest.
- Holds a small FSM for memory-wait timeout detection and saturating statistic counters.

Parameters:
- REG_ADDR_LEN, 4: register-file index width.
- MEM_TIMEOUT, 64: consecutive memory-wait cycles before a timeout is declared (>=2).
- CNT_LEN, 16: width of the statistic counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- fwd_en  in  1  forwarding unit enabled.
- id_src1  in  REG_ADDR_LEN  ID-stage source register 1 (Rn).
- id_src2  in  REG_ADDR_LEN  ID-stage source register 2 (Rm/Rd for store).
- id_use_src1  in  1  ID instruction reads src1.
- id_use_src2  in  1  ID instruction reads src2.
- exe_wb_en  in  1  EXE-stage instruction writes back.
- exe_dest  in  REG_ADDR_LEN  EXE-stage destination.
- exe_mem_read  in  1  EXE-stage instruction is a load.
- mem_wb_en  in  1  MEM-stage instruction writes back.
- mem_dest  in  REG_ADDR_LEN  MEM-stage destination.
- branch_taken  in  1  EXE resolved a taken branch this cycle.
- mem_req  in  1  MEM stage holds a load/store access.
- mem_ready  in  1  SRAM path completes the access this cycle.
- clr_stats  in  1  synchronous clear of the counters.
- pc_freeze  out  1  hold PC.
- if_freeze  out  1  hold the IF/ID register.
- if_flush  out  1  zero the IF/ID register.
- id_flush  out  1  zero the ID/EXE register (bubble).
- pipe_freeze  out  1  hold the ID/EXE, EXE/MEM and MEM/WB registers.
- mem_timeout  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_LEN  hazard bubbles inserted.
- flush_cnt  out  CNT_LEN  branch flushes performed.
- wait_cnt  out  CNT_LEN  total memory-wait cycles.

Behaviour:
- Reset (rst low, asynchronous):
  - state=RUN, internal timeout counter=0, mem_timeout=0, all stat counters=0.
  - All control outputs are forced to 0 while rst is low.
- Control outputs are combinational from the current state and the current-cycle inputs (zero latency). State and counters update on the posedge of clk.
- hazard:
  - fwd_en=0: (id_use_src1 & ((exe_wb_en & id_src1==exe_dest) | (mem_wb_en & id_src1==mem_dest))), OR the same term for src2.
  - fwd_en=1: only load-use, i.e. exe_mem_read & exe_wb_en & ((id_use_src1 & id_src1==exe_dest) | (id_use_src2 & id_src2==exe_dest)).
- mem_stall = mem_req & ~mem_ready.
- FSM states: RUN, MEM_WAIT, TIMEOUT.
  - RUN:
    - If mem_stall: pc_freeze=if_freeze=pipe_freeze=1, flushes=0, next state MEM_WAIT, timeout counter=1.
    - Else if branch_taken: if_flush=1, id_flush=1, freezes=0. Any hazard this cycle is ignored.
    - Else if hazard: pc_freeze=1, if_freeze=1, id_flush=1, pipe_freeze=0.
    - Else: all outputs 0.
  - MEM_WAIT:
    - If mem_stall: all three freezes=1, timeout counter +1. When the counter reaches MEM_TIMEOUT, next state is TIMEOUT.
    - If not mem_stall (access completes): outputs are evaluated exactly as in RUN (branch/hazard may act the same cycle), next state RUN, timeout counter=0.
  - TIMEOUT: pc_freeze=if_freeze=pipe_freeze=1 and mem_timeout=1 permanently. Only reset exits; clr_stats does not.
- Simultaneous events:
  - A flush never coexists with a freeze of the same register.
  - mem_stall masks branch_taken and hazard. EXE holds the branch frozen, so it is re-presented and acted on when the stall ends.
- Counters: +1 on each cycle in which the named condition is applied (id_flush due to hazard / if_flush / mem_stall). They saturate at all-ones. clr_stats=1 clears them to 0 and has priority over increment.
- Reset asserted mid-MEM_WAIT returns to RUN immediately, with all outputs 0.

Test Plan:
- fwd_en=0, id_src1=3, id_use_src1=1, exe_wb_en=1, exe_dest=3 -> pc_freeze=if_freeze=id_flush=1, pipe_freeze=0, stall_cnt 0->1.
- fwd_en=1, same inputs with exe_mem_read=0 -> all outputs 0. Then exe_mem_read=1 -> bubble as above. mem_dest-only match (mem_dest=3) -> no stall.
- branch_taken=1 together with a hazard -> if_flush=id_flush=1, pc_freeze=0, flush_cnt=1, stall_cnt unchanged.
- mem_req=1, mem_ready=0 for 5 cycles, then mem_ready=1 -> freezes high for exactly 5 cycles, wait_cnt=5, state back to RUN. branch_taken held high during the wait -> flush occurs only on the completion cycle.
- MEM_TIMEOUT=8, mem_ready held 0 -> mem_timeout=1 after 8 stall cycles, freezes stay 1. clr_stats does not clear it; rst low clears all.
- Force stall_cnt to all-ones via repeated hazards (CNT_LEN=4: 16 hazard cycles) -> holds 15. Pulse clr_stats during a hazard cycle -> counter reads 0.
